// File: rtl/load_store_unit.sv
// load_store_unit: executes decoded loads and stores against a 32-bit
// word-addressed data bus. Handles byte, halfword and word accesses with
// sign or zero extension. An access that crosses a word boundary is split
// into two bus beats.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op_length,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [4:0]  rd_in,
  output logic        ready,
  output logic        done,
  output logic        error,
  output logic [31:0] read_data,
  output logic        reg_write,
  output logic [4:0]  rd_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    BEAT1,
    RESP,
    ERR
  } state_t;

  state_t state;
  state_t next_state;

  logic        is_load_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic [31:0] word0_q;
  // Only the low three bytes of the second word can ever reach the result.
  logic [23:0] word1_q;

  logic        request_illegal;
  logic [1:0]  off;
  logic [7:0]  base_mask;
  logic [7:0]  lane_mask;
  logic        need_split;
  logic [63:0] store_wide;
  logic [31:0] beat0_addr;
  logic [31:0] aligned;
  logic [31:0] extended;

  assign off        = addr_q[1:0];
  assign lane_mask  = base_mask << off;
  assign need_split = |lane_mask[7:4];
  assign store_wide = {32'h0000_0000, wdata_q} << {off, 3'b000};
  assign beat0_addr = {addr_q[31:2], 2'b00};
  assign rd_out     = rd_q;

  // Classify the incoming request as illegal before it is accepted.
  always_comb begin
    request_illegal = 1'b0;
    if (mem_read == mem_write) begin
      request_illegal = 1'b1;
    end else if (mem_write) begin
      request_illegal = !(mem_op_length inside {3'b000, 3'b001, 3'b010});
    end else begin
      request_illegal = !(mem_op_length inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
  end

  // Base lane mask from the access size (low funct3 bits; BU/HU share B/H).
  always_comb begin
    base_mask = 8'h00;
    case (funct3_q[1:0])
      2'b00:   base_mask = 8'h01;
      2'b01:   base_mask = 8'h03;
      2'b10:   base_mask = 8'h0F;
      default: base_mask = 8'h00;
    endcase
  end

  // Shift the two captured words right by the byte offset.
  always_comb begin
    aligned = word0_q;
    case (off)
      2'd0: aligned = word0_q;
      2'd1: aligned = {word1_q[7:0],  word0_q[31:8]};
      2'd2: aligned = {word1_q[15:0], word0_q[31:16]};
      2'd3: aligned = {word1_q[23:0], word0_q[31:24]};
      default: aligned = word0_q;
    endcase
  end

  // Truncate to the access size and sign- or zero-extend.
  always_comb begin
    extended = aligned;
    case (funct3_q)
      3'b000:  extended = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  extended = {{16{aligned[15]}}, aligned[15:0]};
      3'b100:  extended = {24'h000000, aligned[7:0]};
      3'b101:  extended = {16'h0000, aligned[15:0]};
      default: extended = aligned;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = request_illegal ? ERR : BEAT0;
        end
      end
      BEAT0: begin
        if (bus_ack) begin
          next_state = need_split ? BEAT1 : RESP;
        end
      end
      BEAT1: begin
        if (bus_ack) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the request on acceptance and capture read beats on ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      rd_q       <= 5'd0;
      word0_q    <= 32'h0000_0000;
      word1_q    <= 24'h000000;
    end else begin
      if (state == IDLE && start) begin
        is_load_q  <= mem_read;
        is_store_q <= mem_write;
        funct3_q   <= mem_op_length;
        addr_q     <= address;
        wdata_q    <= write_data;
        rd_q       <= rd_in;
        word0_q    <= 32'h0000_0000;
        word1_q    <= 24'h000000;
      end
      if (state == BEAT0 && bus_ack) begin
        word0_q <= bus_rdata;
      end
      if (state == BEAT1 && bus_ack) begin
        word1_q <= bus_rdata[23:0];
      end
    end
  end

  // Output decode from the current state and the latched request.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    read_data = 32'h0000_0000;
    reg_write = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'h0000_0000;
    bus_wdata = 32'h0000_0000;
    bus_wstrb = 4'b0000;
    case (state)
      IDLE: ready = 1'b1;
      BEAT0: begin
        bus_req  = 1'b1;
        bus_we   = is_store_q;
        bus_addr = beat0_addr;
        if (is_store_q) begin
          bus_wstrb = lane_mask[3:0];
          bus_wdata = store_wide[31:0];
        end
      end
      BEAT1: begin
        bus_req  = 1'b1;
        bus_we   = is_store_q;
        bus_addr = beat0_addr + 32'd4;
        if (is_store_q) begin
          bus_wstrb = lane_mask[7:4];
          bus_wdata = store_wide[63:32];
        end
      end
      RESP: begin
        done      = 1'b1;
        reg_write = is_load_q;
        read_data = is_load_q ? extended : 32'h0000_0000;
      end
      ERR: error = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenario tests for load_store_unit with
// hand-computed expected values. Inputs change and outputs are sampled on
// the falling clock edge; the bus is modelled by driving bus_ack directly.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_op_length;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [4:0]  rd_in;
  logic        ready;
  logic        done;
  logic        error;
  logic [31:0] read_data;
  logic        reg_write;
  logic [4:0]  rd_out;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_cmp;
  int n_err;

  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(mem_read),
    .mem_write(mem_write), .mem_op_length(mem_op_length), .address(address),
    .write_data(write_data), .rd_in(rd_in), .ready(ready), .done(done),
    .error(error), .read_data(read_data), .reg_write(reg_write),
    .rd_out(rd_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present a request for one cycle from a falling edge in IDLE; returns at
  // the falling edge of the cycle after acceptance.
  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    start = 1'b1; mem_read = rd_en; mem_write = wr_en; mem_op_length = f3;
    address = a; write_data = wd; rd_in = rd;
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
    n_cmp++; if ({done, error, reg_write, bus_req, bus_we} !== 5'b0) begin n_err++; $display("[TB] FAIL reset_flags: got %b expected 00000", {done, error, reg_write, bus_req, bus_we}); end
    n_cmp++; if ({read_data, bus_addr, bus_wdata} !== 96'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h expected 0", {read_data, bus_addr, bus_wdata}); end
    n_cmp++; if ({rd_out, bus_wstrb} !== 9'h0) begin n_err++; $display("[TB] FAIL reset_rd_wstrb: got %h expected 0", {rd_out, bus_wstrb}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
    n_cmp++; if ({bus_req, bus_we, ready} !== 3'b100) begin n_err++; $display("[TB] FAIL lw_beat0_ctrl: got %b expected 100", {bus_req, bus_we, ready}); end
    n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_err++; $display("[TB] FAIL lw_addr: got %h expected 00000100", bus_addr); end
    n_cmp++; if (bus_wstrb !== 4'b0000) begin n_err++; $display("[TB] FAIL lw_wstrb: got %b expected 0000", bus_wstrb); end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    n_cmp++; if ({done, reg_write, bus_req} !== 3'b110) begin n_err++; $display("[TB] FAIL lw_done: got %b expected 110", {done, reg_write, bus_req}); end
    n_cmp++; if (read_data !== 32'hDEAD_BEEF) begin n_err++; $display("[TB] FAIL lw_data: got %h expected deadbeef", read_data); end
    n_cmp++; if (rd_out !== 5'd5) begin n_err++; $display("[TB] FAIL lw_rd: got %0d expected 5", rd_out); end
    @(negedge clk);
    n_cmp++; if ({ready, done} !== 2'b10) begin n_err++; $display("[TB] FAIL lw_idle: got %b expected 10", {ready, done}); end
  endtask

  task automatic test_byte_ext;
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7);
    n_cmp++; if (bus_addr !== 32'h0000_0100) begin n_err++; $display("[TB] FAIL lb_addr: got %h expected 00000100", bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if (read_data !== 32'hFFFF_FF80) begin n_err++; $display("[TB] FAIL lb_sext: got %h expected ffffff80", read_data); end
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7);
    bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if ({done, read_data} !== {1'b1, 32'h0000_0080}) begin n_err++; $display("[TB] FAIL lbu_zext: got done=%b data=%h expected done=1 data=00000080", done, read_data); end
    @(negedge clk);
  endtask

  task automatic test_split_load;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0107, 32'h0, 5'd9);
    n_cmp++; if (bus_addr !== 32'h0000_0104) begin n_err++; $display("[TB] FAIL lh_split_addr0: got %h expected 00000104", bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'hAB00_0000;
    @(negedge clk);
    bus_rdata = 32'h0000_00CD;
    n_cmp++; if ({bus_req, done} !== 2'b10) begin n_err++; $display("[TB] FAIL lh_split_beat1: got %b expected 10", {bus_req, done}); end
    n_cmp++; if (bus_addr !== 32'h0000_0108) begin n_err++; $display("[TB] FAIL lh_split_addr1: got %h expected 00000108", bus_addr); end
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if ({done, read_data} !== {1'b1, 32'hFFFF_CDAB}) begin n_err++; $display("[TB] FAIL lh_split_data: got done=%b data=%h expected done=1 data=ffffcdab", done, read_data); end
    @(negedge clk);
  endtask

  task automatic test_split_store;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0206, 32'h1122_3344, 5'd3);
    n_cmp++; if ({bus_req, bus_we, bus_wstrb} !== 6'b11_1100) begin n_err++; $display("[TB] FAIL sw_beat0_ctrl: got %b expected 111100", {bus_req, bus_we, bus_wstrb}); end
    n_cmp++; if ({bus_addr, bus_wdata} !== {32'h0000_0204, 32'h3344_0000}) begin n_err++; $display("[TB] FAIL sw_beat0_bus: got %h/%h expected 00000204/33440000", bus_addr, bus_wdata); end
    bus_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_we, bus_wstrb} !== 6'b11_0011) begin n_err++; $display("[TB] FAIL sw_beat1_ctrl: got %b expected 110011", {bus_req, bus_we, bus_wstrb}); end
    n_cmp++; if ({bus_addr, bus_wdata} !== {32'h0000_0208, 32'h0000_1122}) begin n_err++; $display("[TB] FAIL sw_beat1_bus: got %h/%h expected 00000208/00001122", bus_addr, bus_wdata); end
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if ({done, reg_write, read_data} !== {2'b10, 32'h0}) begin n_err++; $display("[TB] FAIL sw_done: got done=%b rw=%b data=%h expected 1 0 0", done, reg_write, read_data); end
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0010, 32'hAAAA_5555, 5'd1);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus_req, ready, done, bus_wstrb, bus_addr, bus_wdata} !== {3'b100, 4'b0011, 32'h0000_0010, 32'hAAAA_5555}) begin
        n_err++;
        $display("[TB] FAIL sh_wait_hold%0d: got req=%b rdy=%b done=%b strb=%b addr=%h wdata=%h expected 1 0 0 0011 00000010 aaaa5555",
                 i, bus_req, ready, done, bus_wstrb, bus_addr, bus_wdata);
      end
      if (i == 3) bus_ack = 1'b1;
      @(negedge clk);
    end
    bus_ack = 1'b0;
    n_cmp++; if ({done, reg_write, ready} !== 3'b100) begin n_err++; $display("[TB] FAIL sh_wait_done: got %b expected 100", {done, reg_write, ready}); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0020, 32'h0, 5'd2);
    n_cmp++; if ({error, bus_req, done, ready} !== 4'b1000) begin n_err++; $display("[TB] FAIL ill_load_f3: got %b expected 1000", {error, bus_req, done, ready}); end
    @(negedge clk);
    n_cmp++; if ({error, bus_req, ready} !== 3'b001) begin n_err++; $display("[TB] FAIL ill_recover: got %b expected 001", {error, bus_req, ready}); end
    issue(1'b0, 1'b1, 3'b100, 32'h0000_0020, 32'h0, 5'd2);
    n_cmp++; if ({error, bus_req} !== 2'b10) begin n_err++; $display("[TB] FAIL ill_store_f3: got %b expected 10", {error, bus_req}); end
    @(negedge clk);
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0020, 32'h0, 5'd2);
    n_cmp++; if ({error, bus_req} !== 2'b10) begin n_err++; $display("[TB] FAIL ill_both: got %b expected 10", {error, bus_req}); end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    issue(1'b1, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd4);
    n_cmp++; if (bus_addr !== 32'hFFFF_FFFC) begin n_err++; $display("[TB] FAIL wrap_addr0: got %h expected fffffffc", bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h1200_0000;
    @(negedge clk);
    bus_rdata = 32'h0000_0034;
    n_cmp++; if (bus_addr !== 32'h0000_0000) begin n_err++; $display("[TB] FAIL wrap_addr1: got %h expected 00000000", bus_addr); end
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if (read_data !== 32'h0000_3412) begin n_err++; $display("[TB] FAIL wrap_data: got %h expected 00003412", read_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0107, 32'h0, 5'd6);
    bus_ack = 1'b1; bus_rdata = 32'hAB00_0000;
    @(negedge clk);
    bus_ack = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({bus_req, ready} !== 2'b01) begin n_err++; $display("[TB] FAIL rst_mid_abort: got %b expected 01", {bus_req, ready}); end
    bus_ack = 1'b1; bus_rdata = 32'h0000_00CD;
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if ({done, bus_req, ready} !== 3'b001) begin n_err++; $display("[TB] FAIL rst_mid_late_ack: got %b expected 001", {done, bus_req, ready}); end
    @(negedge clk);
    n_cmp++; if ({done, reg_write, ready} !== 3'b001) begin n_err++; $display("[TB] FAIL rst_mid_no_done: got %b expected 001", {done, reg_write, ready}); end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd8);
    bus_ack = 1'b1; bus_rdata = 32'h0102_0304;
    @(negedge clk);
    bus_ack = 1'b0;
    start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_op_length = 3'b100;
    address = 32'h0000_0101; rd_in = 5'd11;
    n_cmp++; if ({done, ready, read_data} !== {2'b10, 32'h0102_0304}) begin n_err++; $display("[TB] FAIL b2b_first: got done=%b rdy=%b data=%h expected 1 0 01020304", done, ready, read_data); end
    @(negedge clk);
    n_cmp++; if ({ready, bus_req} !== 2'b10) begin n_err++; $display("[TB] FAIL b2b_idle: got %b expected 10", {ready, bus_req}); end
    @(negedge clk);
    start = 1'b0; mem_read = 1'b0;
    n_cmp++; if ({bus_req, bus_addr} !== {1'b1, 32'h0000_0100}) begin n_err++; $display("[TB] FAIL b2b_second_beat: got req=%b addr=%h expected 1 00000100", bus_req, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h0000_AB00;
    @(negedge clk);
    bus_ack = 1'b0;
    n_cmp++; if ({done, read_data, rd_out} !== {1'b1, 32'h0000_00AB, 5'd11}) begin n_err++; $display("[TB] FAIL b2b_second_data: got done=%b data=%h rd=%0d expected 1 000000ab 11", done, read_data, rd_out); end
    @(negedge clk);
  endtask

  // Drive the scenarios in sequence and report the totals.
  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_op_length = 3'b000; address = 32'h0; write_data = 32'h0; rd_in = 5'd0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    test_reset();
    test_lw();
    test_byte_ext();
    test_split_load();
    test_split_store();
    test_wait_states();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
